score_bcd: RTL and testbench
============================

SCORE_BCD -- requirements
Module: score_bcd

Interface
REQ-001 Parameter WIDTH, default 24, bit width of the binary score input.
REQ-002 Parameter DIGITS, default 3, number of decimal digits produced.
REQ-003 Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 score  input  WIDTH  unsigned binary score from the obstacle stage.
REQ-006 start  input  1  conversion request; sampled only in IDLE.
REQ-007 auto_en  input  1  when high, a change in score triggers a conversion with no start pulse.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  single-cycle pulse marking a completed conversion.
REQ-010 ovf  output  1  high when the last converted score was at or above 10^DIGITS.
REQ-011 digits  output  DIGITS x 4 (unpacked)  BCD digits; index 0 is most significant, index DIGITS-1 is units; feeds HexDriver and color_mapper.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, SHIFT and DONE.
REQ-013 In IDLE, a trigger SHALL move the FSM to LOAD on the next edge; trigger = start OR (auto_en AND score != last_score).
REQ-014 LOAD (1 cycle) SHALL:
- capture the raw score into last_score;
- capture the clamped value min(score, 10^DIGITS-1) into a WIDTH-bit shift register;
- set ovf_next = (score >= 10^DIGITS);
- clear the BCD accumulator and the bit counter.
REQ-015 SHIFT SHALL last exactly WIDTH cycles. Each cycle: every accumulator nibble >= 5 gets +3, then {accumulator, shift register} shifts left by 1, MSB first.
REQ-016 On the edge leaving the last SHIFT cycle, the FSM SHALL:
- load the accumulator into digits;
- load ovf_next into ovf;
- set done;
- enter DONE.
REQ-017 DONE SHALL last 1 cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-018 Latency: trigger sampled at edge 0 -> done and new digits visible in cycle WIDTH+2 (cycle 26 for WIDTH=24).
REQ-019 digits and ovf SHALL hold their previous values from LOAD through the final SHIFT cycle; no partial result is ever visible.
REQ-020 start and score changes while busy SHALL be ignored; the captured operand is unaffected.
REQ-021 A trigger asserted during the DONE cycle SHALL be ignored; it is acted on only if still present in IDLE.
REQ-022 Saturation: because the operand is clamped, accumulator nibbles SHALL never exceed 9 and no carry SHALL be lost.
REQ-023 With auto_en=1 and score stable, no further conversions SHALL occur after the one that captured that score.
REQ-024 Conversion SHALL use no divider or modulo operator; only compare, add-3 and shift logic.

Reset
REQ-025 Reset SHALL force, on the next edge, from any state including mid-SHIFT:
- state=IDLE, busy=0, done=0, ovf=0;
- all digits=0, last_score=0;
- accumulator, shift register and counter = 0.
REQ-026 Reset SHALL take priority over a simultaneous trigger; the first conversion may start on the edge after Reset deasserts.
REQ-027 After reset, score=0 with auto_en=1 SHALL NOT trigger a conversion, since the digits already read 0.

Verification
REQ-028 Reset, score=123, 1-cycle start pulse -> busy 1 for cycles 1-26, done=1 in cycle 26 only; digits={1,2,3}, ovf=0.
REQ-029 score=999 start -> digits={9,9,9}, ovf=0. Then score=1000 start -> {9,9,9}, ovf=1. Then score=24'hFFFFFF start -> {9,9,9}, ovf=1.
REQ-030 score=45 start; at cycle 5 set score=77 and pulse start -> single done at cycle 26 with digits={0,4,5}; no second conversion (auto_en=0).
REQ-031 Convert 58 (digits={0,5,8}). Start a conversion of 321 and assert Reset at cycle 10 -> next cycle digits={0,0,0}, busy=0, done=0; start afterwards converts normally to {3,2,1}.
REQ-032 auto_en=1, score 0 -> 42 -> held -> exactly one done with {0,4,2}; then score 42 -> 57 -> exactly one more done with {0,5,7}; score held 200 cycles -> no further done.

Source files
------------

// File: rtl/score_bcd.sv
// rtl/score_bcd.sv - binary score to saturating BCD converter (shift/add-3)
module score_bcd #(
    parameter int WIDTH  = 24,
    parameter int DIGITS = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] score,
    input  logic             start,
    input  logic             auto_en,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       digits [0:DIGITS-1]
);

    localparam int AW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0]      LIMIT = pow10(DIGITS);
    localparam logic [WIDTH-1:0] CLAMP = WIDTH'(LIMIT - 64'd1);
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] last_score_q, last_score_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    digits_q, digits_d;
    logic             ovf_q, ovf_d;
    logic             ovf_next_q, ovf_next_d;
    logic             done_q, done_d;

    logic             over;
    logic             trigger;
    logic [AW-1:0]    acc_adj;
    logic [AW-1:0]    acc_sh;
    logic [WIDTH-1:0] sr_sh;

    assign over    = 64'(score) >= LIMIT;
    assign trigger = start | (auto_en & (score != last_score_q));

    // Operand is clamped below 10^DIGITS, so no nibble ever leaves 0..9.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
        end
        acc_sh = {acc_adj[AW-2:0], sr_q[WIDTH-1]};
        sr_sh  = {sr_q[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        state_d      = state_q;
        last_score_d = last_score_q;
        sr_d         = sr_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        digits_d     = digits_q;
        ovf_d        = ovf_q;
        ovf_next_d   = ovf_next_q;
        done_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trigger) state_d = LOAD;
            end
            LOAD: begin
                last_score_d = score;
                sr_d         = over ? CLAMP : score;
                ovf_next_d   = over;
                acc_d        = '0;
                cnt_d        = '0;
                state_d      = SHIFT;
            end
            SHIFT: begin
                acc_d = acc_sh;
                sr_d  = sr_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    digits_d = acc_sh;
                    ovf_d    = ovf_next_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            last_score_q <= '0;
            sr_q         <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            digits_q     <= '0;
            ovf_q        <= 1'b0;
            ovf_next_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            sr_q         <= sr_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            digits_q     <= digits_d;
            ovf_q        <= ovf_d;
            ovf_next_q   <= ovf_next_d;
            done_q       <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign ovf  = ovf_q;

    always_comb begin
        for (int i = 0; i < DIGITS; i++) digits[i] = digits_q[(DIGITS-1-i)*4 +: 4];
    end

endmodule

// File: tb/tb_score_bcd.sv
// tb/tb_score_bcd.sv - scoreboard bench for score_bcd
module tb_score_bcd;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [23:0] score = '0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        busy, done, ovf;
    logic [3:0]  digits [0:2];

    score_bcd #(.WIDTH(24), .DIGITS(3)) dut (
        .Clk(Clk), .Reset(Reset), .score(score), .start(start), .auto_en(auto_en),
        .busy(busy), .done(done), .ovf(ovf), .digits(digits)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [12:0] exp_q [$];

    function automatic logic [12:0] act_val();
        return {digits[0], digits[1], digits[2], ovf};
    endfunction

    // Monitor: every done pulse pops one expected result.
    always @(negedge Clk) begin
        if (!Reset && done) begin
            logic [12:0] e;
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got digits/ovf=%h, none expected", act_val());
            end else begin
                e = exp_q.pop_front();
                if (act_val() !== e) begin
                    bad++;
                    $display("FAIL result: got digits/ovf=%h, required %h", act_val(), e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
        tick();
    endtask

    task automatic convert(input logic [23:0] s, input logic [11:0] d, input logic o);
        exp_q.push_back({d, o});
        score = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    int base;

    initial begin
        // Reset wins over a simultaneous start
        start = 1'b1;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_ovf", {31'd0, ovf}, 32'd0);
        check("reset_digits", {20'd0, digits[0], digits[1], digits[2]}, 32'h0);
        start = 1'b0;
        Reset = 1'b0;
        auto_en = 1'b1;
        tick(); tick(); tick();
        check("auto_zero_idle", {31'd0, busy}, 32'd0);
        auto_en = 1'b0;

        // Cycle-accurate busy/done window for 123
        exp_q.push_back({12'h123, 1'b0});
        score = 24'd123;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            if (k == 1 || k == 25 || k == 26 || k == 27) begin
                check($sformatf("busy_c%0d", k), {31'd0, busy}, (k <= 26) ? 32'd1 : 32'd0);
                check($sformatf("done_c%0d", k), {31'd0, done}, (k == 26) ? 32'd1 : 32'd0);
            end
            if (k == 10) check("digits_hold", {20'd0, digits[0], digits[1], digits[2]}, 32'h0);
            tick();
        end

        convert(24'd999, 12'h999, 1'b0);
        convert(24'd1000, 12'h999, 1'b1);
        convert(24'hFFFFFF, 12'h999, 1'b1);
        convert(24'd7, 12'h007, 1'b0);

        // Start and score changes while busy are ignored
        base = done_cnt;
        exp_q.push_back({12'h045, 1'b0});
        score = 24'd45;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        score = 24'd77;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        repeat (40) tick();
        check("busy_ignore_count", done_cnt - base, 32'd1);

        // Reset mid-conversion
        convert(24'd58, 12'h058, 1'b0);
        score = 24'd321;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mid_rst_digits", {20'd0, digits[0], digits[1], digits[2]}, 32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        convert(24'd321, 12'h321, 1'b0);

        // Auto-trigger on score change only
        score = 24'd0;
        do_reset();
        auto_en = 1'b1;
        tick(); tick();
        base = done_cnt;
        exp_q.push_back({12'h042, 1'b0});
        score = 24'd42;
        tick();
        wait_done();
        repeat (30) tick();
        check("auto_42_count", done_cnt - base, 32'd1);
        base = done_cnt;
        exp_q.push_back({12'h057, 1'b0});
        score = 24'd57;
        tick();
        wait_done();
        repeat (30) tick();
        check("auto_57_count", done_cnt - base, 32'd1);
        base = done_cnt;
        repeat (200) tick();
        check("auto_stable_count", done_cnt - base, 32'd0);
        auto_en = 1'b0;

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
